pattern_scan_arbiter: RTL and testbench

Shares one serial 1101 sequence detector between `N_REQ` requesters. Each requester presents a `DATA_W`-bit word. The block grants one requester at a time (round-robin), shifts the word MSB-first through a Mealy 1101 detector at one bit per clock, counts overlapping matches, and returns the count with a one-cycle `done` pulse. It sits between the pattern-checking datapath and its clients, and is the only driver of the detector.

---
 rtl/pattern_scan_arbiter_pkg.sv | 18 +
 rtl/pattern_scan_arbiter_if.sv | 25 ++
 rtl/pattern_scan_arbiter_detector.sv | 39 +++
 rtl/pattern_scan_arbiter.sv | 143 ++++++++++++++
 tb/tb_pattern_scan_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_arbiter_pkg.sv
// Shared encodings for the pattern scan arbiter: job FSM states and
// the 1101 detector states.
package pattern_scan_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SHIFT  = 2'b01,
      ST_REPORT = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      DS_NONE = 2'b00,
      DS_1    = 2'b01,
      DS_11   = 2'b10,
      DS_110  = 2'b11
   } det_state_e;

endpackage

// File: rtl/pattern_scan_arbiter_if.sv
// Requester-side bus of the pattern scan arbiter; clients drive req/data,
// the arbiter returns grant, job status and the match count.
interface pattern_scan_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 1)
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] data;
   logic [N_REQ-1:0]        grant;
   logic                    busy;
   logic                    done;
   logic [CNT_W-1:0]        match_cnt;
   logic [1:0]              status;

   modport master (
      output req, data,
      input  grant, busy, done, match_cnt, status
   );

   modport slave (
      input  req, data,
      output grant, busy, done, match_cnt, status
   );
endinterface

// File: rtl/pattern_scan_arbiter_detector.sv
// Overlapping Mealy detector for the serial pattern 1101; clr restarts it
// so that matches never straddle two jobs.
module seq1101_detector
   import pattern_scan_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic in,
   input  logic en,
   output logic hit
);

   det_state_e state_q, state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= DS_NONE;
      else        state_q <= state_d;
   end

   // After a hit the trailing 1 is kept so that 1101101 counts twice.
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = DS_NONE;
      end else if (en) begin
         case (state_q)
            DS_NONE: state_d = in ? DS_1  : DS_NONE;
            DS_1:    state_d = in ? DS_11 : DS_NONE;
            DS_11:   state_d = in ? DS_11 : DS_110;
            DS_110:  state_d = in ? DS_1  : DS_NONE;
            default: state_d = DS_NONE;
         endcase
      end
   end

   assign hit = en && (state_q == DS_110) && in;

endmodule

// File: rtl/pattern_scan_arbiter.sv
// Round-robin arbiter that lends one serial 1101 detector to N_REQ requesters.
//   state     | meaning
//   ST_IDLE   | no job; arbitrate and latch the winner's word when any req is high
//   ST_SHIFT  | feed one bit per clock MSB-first into the detector, count hits
//   ST_REPORT | done pulse with final count, advance rr pointer past the winner
module pattern_scan_arbiter
   import pattern_scan_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic clk,
   input  logic reset,
   pattern_scan_arbiter_if.slave bus
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BIT_W = $clog2(DATA_W);

   state_e              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                start;
   logic                hit;
   logic [PTR_W-1:0]    pick;
   logic [DATA_W-1:0]   pick_word;

   // First set request at or after ptr, wrapping around.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] sel;
      logic             found;
      logic [PTR_W:0]   idx;
      sel   = ptr;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(N_REQ)) idx = idx - (PTR_W+1)'(N_REQ);
         if (!found && r[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[PTR_W-1:0];
         end
      end
      return sel;
   endfunction

   assign start = (state_q == ST_IDLE) && (|bus.req);
   assign pick  = rr_pick(bus.req, rr_ptr_q);

   always_comb begin
      pick_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick == PTR_W'(i)) pick_word = bus.data[i*DATA_W +: DATA_W];
      end
   end

   seq1101_detector u_det (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .in    (shreg_q[DATA_W-1]),
      .en    (state_q == ST_SHIFT),
      .hit   (hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (|bus.req) state_d = ST_SHIFT;
         ST_SHIFT:  if (bit_cnt_q == '0) state_d = ST_REPORT;
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy   = (state_q == ST_SHIFT) || (state_q == ST_REPORT);
      bus.done   = (state_q == ST_REPORT);
      bus.status = state_q;
   end

   assign bus.grant     = grant_q;
   assign bus.match_cnt = cnt_q;

   always_comb begin
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_idx_d = gnt_idx_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               grant_d   = N_REQ'(1) << pick;
               gnt_idx_d = pick;
               shreg_d   = pick_word;
               bit_cnt_d = BIT_W'(DATA_W - 1);
               cnt_d     = '0;
            end
         end
         ST_SHIFT: begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
            if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - 1'b1;
         end
         ST_REPORT: begin
            grant_d  = '0;
            rr_ptr_d = (gnt_idx_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
         end
         default: grant_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
      end else begin
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Directed self-checking bench for pattern_scan_arbiter (N_REQ=4, DATA_W=8).
module tb_pattern_scan_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = $clog2(DATA_W + 1);

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pattern_scan_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   pattern_scan_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic set_word(input int i, input logic [DATA_W-1:0] w);
      bus.data[i*DATA_W +: DATA_W] = w;
   endtask

   // Observes one job: cyc is the cycle (1 = cycle after the start edge) in
   // which done is seen, -1 if it never comes within the budget.
   task automatic wait_done(input int drop_at, output int cyc, output int gcnt,
                            output int bad_oh, output logic [N_REQ-1:0] g,
                            output logic [CNT_W-1:0] cnt);
      cyc = -1; gcnt = 0; bad_oh = 0; g = '0; cnt = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == drop_at) bus.req = '0;
         if (bus.grant != '0) gcnt++;
         if (!$onehot0(bus.grant)) bad_oh++;
         if (bus.done) begin
            cyc = c; g = bus.grant; cnt = bus.match_cnt;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.req = '0; bus.data = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.match_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.match_cnt); end
      n_checks++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b expected 00", bus.status); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL idle_no_req: got %b expected 00", bus.status); end
   endtask

   task automatic test_single_job();
      int cyc, gcnt, bad; logic [N_REQ-1:0] g; logic [CNT_W-1:0] cnt;
      set_word(0, 8'hDA);
      bus.req = 4'b0001;
      wait_done(0, cyc, gcnt, bad, g, cnt);
      bus.req = '0;
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL single_latency: got %0d expected 9", cyc); end
      n_checks++; if (gcnt !== 9) begin n_fail++; $display("FAIL single_grant_cycles: got %0d expected 9", gcnt); end
      n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", g); end
      n_checks++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL single_cnt: got %0d expected 2", cnt); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_onehot: got %0d bad cycles expected 0", bad); end
      @(negedge clk);
      n_checks++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL single_back_idle: got %b expected 00", bus.status); end
      n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_clear: got %b expected 0000", bus.grant); end
      n_checks++; if (bus.match_cnt !== 4'd2) begin n_fail++; $display("FAIL single_cnt_hold: got %0d expected 2", bus.match_cnt); end
   endtask

   task automatic test_patterns();
      logic [7:0] words [4];
      int         exps  [4];
      int cyc, gcnt, bad; logic [N_REQ-1:0] g; logic [CNT_W-1:0] cnt;
      words = '{8'hFF, 8'h0D, 8'h6D, 8'h00};
      exps  = '{0, 1, 2, 0};
      for (int i = 0; i < 4; i++) begin
         set_word(1, words[i]);
         bus.req = 4'b0010;
         wait_done(0, cyc, gcnt, bad, g, cnt);
         bus.req = '0;
         n_checks++; if (cnt !== CNT_W'(exps[i])) begin n_fail++; $display("FAIL pattern_%02h_cnt: got %0d expected %0d", words[i], cnt, exps[i]); end
         n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL pattern_%02h_grant: got %b expected 0010", words[i], g); end
         n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL pattern_%02h_latency: got %0d expected 9", words[i], cyc); end
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] eg [4];
      int               ec [4];
      int cyc, gcnt, bad; logic [N_REQ-1:0] g; logic [CNT_W-1:0] cnt;
      set_word(0, 8'h0D); set_word(1, 8'hDA); set_word(2, 8'h6D); set_word(3, 8'hFF);
      pulse_reset();
      // req=0101 held: 0,2,0,2 with one idle cycle between jobs
      eg = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      ec = '{1, 2, 1, 2};
      bus.req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         wait_done(0, cyc, gcnt, bad, g, cnt);
         n_checks++; if (g !== eg[i]) begin n_fail++; $display("FAIL rr_a_grant_%0d: got %b expected %b", i, g, eg[i]); end
         n_checks++; if (cnt !== CNT_W'(ec[i])) begin n_fail++; $display("FAIL rr_a_cnt_%0d: got %0d expected %0d", i, cnt, ec[i]); end
         n_checks++; if (cyc !== ((i == 0) ? 9 : 10)) begin n_fail++; $display("FAIL rr_a_period_%0d: got %0d expected %0d", i, cyc, (i == 0) ? 9 : 10); end
         n_checks++; if (gcnt !== 9) begin n_fail++; $display("FAIL rr_a_grant_cycles_%0d: got %0d expected 9", i, gcnt); end
      end
      bus.req = '0;
      @(negedge clk);
      pulse_reset();
      // first job to 0, then requester 3 joins: 2,3,0
      eg = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
      ec = '{1, 2, 0, 1};
      bus.req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         wait_done(0, cyc, gcnt, bad, g, cnt);
         if (i == 0) bus.req = 4'b1101;
         n_checks++; if (g !== eg[i]) begin n_fail++; $display("FAIL rr_b_grant_%0d: got %b expected %b", i, g, eg[i]); end
         n_checks++; if (cnt !== CNT_W'(ec[i])) begin n_fail++; $display("FAIL rr_b_cnt_%0d: got %0d expected %0d", i, cnt, ec[i]); end
         n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rr_b_onehot_%0d: got %0d bad cycles expected 0", i, bad); end
      end
      bus.req = '0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back_isolation();
      int cyc, gcnt, bad; logic [N_REQ-1:0] g; logic [CNT_W-1:0] cnt;
      set_word(1, 8'h01);
      bus.req = 4'b0010;
      wait_done(0, cyc, gcnt, bad, g, cnt);
      set_word(1, 8'hA0);
      n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL iso_first_cnt: got %0d expected 0", cnt); end
      wait_done(0, cyc, gcnt, bad, g, cnt);
      bus.req = '0;
      n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL iso_second_cnt: got %0d expected 0", cnt); end
      n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL iso_period: got %0d expected 10", cyc); end
      n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL iso_grant: got %b expected 0010", g); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_job();
      int cyc, gcnt, bad, seen; logic [N_REQ-1:0] g; logic [CNT_W-1:0] cnt;
      set_word(2, 8'hDA);
      bus.req = 4'b0100;
      repeat (5) @(negedge clk);
      n_checks++; if (bus.match_cnt !== 4'd1) begin n_fail++; $display("FAIL midjob_cnt: got %0d expected 1", bus.match_cnt); end
      n_checks++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL midjob_grant: got %b expected 0100", bus.grant); end
      reset = 1'b0;
      #1;
      n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL async_grant: got %b expected 0000", bus.grant); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL async_status: got %b expected 00", bus.status); end
      n_checks++; if (bus.match_cnt !== 4'd0) begin n_fail++; $display("FAIL async_cnt: got %0d expected 0", bus.match_cnt); end
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL async_no_done: got %0d done cycles expected 0", seen); end
      reset = 1'b1;
      wait_done(0, cyc, gcnt, bad, g, cnt);
      bus.req = '0;
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL rerun_latency: got %0d expected 9", cyc); end
      n_checks++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL rerun_cnt: got %0d expected 2", cnt); end
      n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL rerun_grant: got %b expected 0100", g); end
      @(negedge clk);
   endtask

   task automatic test_dropped_req();
      int cyc, gcnt, bad, regrant; logic [N_REQ-1:0] g; logic [CNT_W-1:0] cnt;
      set_word(2, 8'h6D);
      bus.req = 4'b0100;
      wait_done(3, cyc, gcnt, bad, g, cnt);
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL drop_latency: got %0d expected 9", cyc); end
      n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL drop_grant: got %b expected 0100", g); end
      n_checks++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 2", cnt); end
      regrant = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.grant != '0) regrant++;
      end
      n_checks++; if (regrant !== 0) begin n_fail++; $display("FAIL drop_no_regrant: got %0d grant cycles expected 0", regrant); end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_patterns();
      test_round_robin();
      test_back_to_back_isolation();
      test_reset_mid_job();
      test_dropped_req();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
